// File: rtl/timepulse_ring.sv
// Twelve-phase time-pulse ring stepped by ordered RT/WT/CT timer pulses,
// with a memory-cycle counter and sticky sequence-error / stall flags.
module timepulse_ring #(
  parameter int STALL_LIM = 64
) (
  input  logic        CLOCK,
  input  logic        SIM_RST,
  input  logic        RT,
  input  logic        WT,
  input  logic        CT,
  input  logic        STOP,
  input  logic        CLRERR,
  output logic [11:0] T,
  output logic [3:0]  TSTAGE,
  output logic        EOMCY,
  output logic [15:0] MCTCNT,
  output logic        SEQERR,
  output logic        STALL
);

  localparam logic [1:0] WAIT_RT = 2'd0;
  localparam logic [1:0] WAIT_WT = 2'd1;
  localparam logic [1:0] WAIT_CT = 2'd2;
  localparam logic [9:0] LIM     = 10'(STALL_LIM);

  logic       rt_prev, wt_prev, ct_prev;
  logic       rt_edge, wt_edge, ct_edge, any_edge;
  logic [1:0] state, state_next;
  logic       advance, seq_set, stall_set;
  logic [9:0] stall_cnt, stall_cnt_next;

  // Edges compare the live input against last cycle's sample, so the ring
  // moves on the very clock edge that first sees CT high.
  assign rt_edge  = RT & ~rt_prev;
  assign wt_edge  = WT & ~wt_prev;
  assign ct_edge  = CT & ~ct_prev;
  assign any_edge = rt_edge | wt_edge | ct_edge;

  always_comb begin
    state_next = state;
    advance    = 1'b0;
    seq_set    = 1'b0;
    if (STOP) begin
      state_next = WAIT_RT;
    end else if (any_edge) begin
      // Anything other than the single expected edge is an ordering error.
      state_next = WAIT_RT;
      seq_set    = 1'b1;
      case (state)
        WAIT_RT: if (rt_edge && !wt_edge && !ct_edge) begin
          state_next = WAIT_WT;
          seq_set    = 1'b0;
        end
        WAIT_WT: if (wt_edge && !rt_edge && !ct_edge) begin
          state_next = WAIT_CT;
          seq_set    = 1'b0;
        end
        WAIT_CT: if (ct_edge && !rt_edge && !wt_edge) begin
          state_next = WAIT_RT;
          seq_set    = 1'b0;
          advance    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    stall_cnt_next = stall_cnt;
    if (STOP || ct_edge) begin
      stall_cnt_next = 10'd0;
    end else if (stall_cnt >= LIM) begin
      stall_cnt_next = LIM;
    end else begin
      stall_cnt_next = stall_cnt + 10'd1;
    end
    stall_set = ~STOP & (stall_cnt_next == LIM);
  end

  // Previous samples start high so inputs already asserted at release are ignored.
  always_ff @(posedge CLOCK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      rt_prev <= 1'b1;
      wt_prev <= 1'b1;
      ct_prev <= 1'b1;
    end else begin
      rt_prev <= RT;
      wt_prev <= WT;
      ct_prev <= CT;
    end
  end

  always_ff @(posedge CLOCK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      state     <= WAIT_RT;
      T         <= 12'h800;
      TSTAGE    <= 4'd12;
      EOMCY     <= 1'b0;
      MCTCNT    <= 16'h0000;
      stall_cnt <= 10'd0;
    end else begin
      state     <= state_next;
      stall_cnt <= stall_cnt_next;
      EOMCY     <= advance & T[11];
      if (advance) begin
        T      <= {T[10:0], T[11]};
        TSTAGE <= (TSTAGE == 4'd12) ? 4'd1 : TSTAGE + 4'd1;
        if (T[11]) begin
          MCTCNT <= MCTCNT + 16'd1;
        end
      end
    end
  end

  // A set condition outranks a simultaneous clear request.
  always_ff @(posedge CLOCK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      SEQERR <= 1'b0;
      STALL  <= 1'b0;
    end else begin
      SEQERR <= seq_set | (SEQERR & ~CLRERR);
      STALL  <= stall_set | (STALL & ~CLRERR);
    end
  end

endmodule

// File: tb/tb_timepulse_ring.sv
// Self-checking bench for timepulse_ring: a cycle-level behavioural model
// checked every cycle, plus hand-computed expectations at key points.
module tb_timepulse_ring;

  localparam int LIM = 64;

  logic        clock, sim_rst, rt, wt, ct, stop, clrerr;
  logic [11:0] t;
  logic [3:0]  tstage;
  logic        eomcy, seqerr, stall;
  logic [15:0] mctcnt;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 0;

  // Model state: current pulse number, which timer pulse is expected next
  // (0=RT, 1=WT, 2=CT), cycle counts and flags.
  int m_stage, m_phase, m_cnt, m_idle, m_edges, m_which;
  bit m_eom, m_seqerr, m_stall, m_prt, m_pwt, m_pct, m_er, m_ew, m_ec, m_set;

  timepulse_ring #(.STALL_LIM(LIM)) dut (
    .CLOCK(clock), .SIM_RST(sim_rst), .RT(rt), .WT(wt), .CT(ct),
    .STOP(stop), .CLRERR(clrerr), .T(t), .TSTAGE(tstage), .EOMCY(eomcy),
    .MCTCNT(mctcnt), .SEQERR(seqerr), .STALL(stall)
  );

  initial clock = 0;
  always #5 clock = ~clock;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(posedge clock or negedge sim_rst) begin
    if (!sim_rst) begin
      m_stage = 12; m_phase = 0; m_cnt = 0; m_idle = 0;
      m_eom = 0; m_seqerr = 0; m_stall = 0;
      m_prt = 1; m_pwt = 1; m_pct = 1;
    end else begin
      m_er = rt && !m_prt;
      m_ew = wt && !m_pwt;
      m_ec = ct && !m_pct;
      m_prt = rt; m_pwt = wt; m_pct = ct;
      m_edges = int'(m_er) + int'(m_ew) + int'(m_ec);
      m_which = m_er ? 0 : (m_ew ? 1 : 2);
      m_eom = 0;
      m_set = 0;
      if (stop) begin
        m_phase = 0;
        m_idle = 0;
      end else begin
        if (m_edges == 1 && m_which == m_phase) begin
          if (m_phase == 2) begin
            m_stage = (m_stage % 12) + 1;
            if (m_stage == 1) begin
              m_eom = 1;
              m_cnt = (m_cnt + 1) % 65536;
            end
          end
          m_phase = (m_phase + 1) % 3;
        end else if (m_edges > 0) begin
          m_set = 1;
          m_phase = 0;
        end
        m_idle = m_ec ? 0 : ((m_idle < LIM) ? m_idle + 1 : LIM);
      end
      m_seqerr = m_set | (m_seqerr & !clrerr);
      m_stall = (!stop && m_idle == LIM) | (m_stall & !clrerr);
    end
  end

  // Continuous comparison of every output against the model.
  always @(negedge clock) begin
    logic [11:0] exp_t;
    if (cmp_en) begin
      exp_t = 12'd1 << (m_stage - 1);
      check_output("cyc_T", 32'(t), 32'(exp_t));
      check_output("cyc_TSTAGE", 32'(tstage), 32'(m_stage));
      check_output("cyc_EOMCY", 32'(eomcy), 32'(m_eom));
      check_output("cyc_MCTCNT", 32'(mctcnt), 32'(m_cnt));
      check_output("cyc_SEQERR", 32'(seqerr), 32'(m_seqerr));
      check_output("cyc_STALL", 32'(stall), 32'(m_stall));
    end
  end

  // One clock cycle: drive at negedge, return just after the sampling edge.
  task automatic apply_stimulus(input bit r, input bit w, input bit c,
                                input bit s, input bit clr);
    @(negedge clock);
    rt = r; wt = w; ct = c; stop = s; clrerr = clr;
    @(posedge clock);
    #1;
  endtask

  task automatic triplet(input bit s);
    apply_stimulus(1, 0, 0, s, 0);
    apply_stimulus(0, 1, 0, s, 0);
    apply_stimulus(0, 0, 1, s, 0);
  endtask

  task automatic idle(input int n, input bit s);
    for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, s, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_T"}, 32'(t), 32'h800);
    check_output({tag, "_TSTAGE"}, 32'(tstage), 32'd12);
    check_output({tag, "_EOMCY"}, 32'(eomcy), 32'd0);
    check_output({tag, "_MCTCNT"}, 32'(mctcnt), 32'd0);
    check_output({tag, "_SEQERR"}, 32'(seqerr), 32'd0);
    check_output({tag, "_STALL"}, 32'(stall), 32'd0);
  endtask

  initial begin
    sim_rst = 0; rt = 0; wt = 0; ct = 0; stop = 0; clrerr = 0;
    repeat (3) @(posedge clock);
    #1;
    cmp_en = 1;
    check_reset_values("rst");
    sim_rst = 1;
    idle(2, 0);

    // Full memory cycle of twelve ordered triplets.
    triplet(0);
    check_output("first_T", 32'(t), 32'h001);
    check_output("first_EOMCY", 32'(eomcy), 32'd1);
    check_output("first_MCTCNT", 32'(mctcnt), 32'd1);
    for (int i = 0; i < 11; i++) triplet(0);
    check_output("full_T", 32'(t), 32'h800);
    check_output("full_TSTAGE", 32'(tstage), 32'd12);
    check_output("full_MCTCNT", 32'(mctcnt), 32'd1);
    check_output("full_SEQERR", 32'(seqerr), 32'd0);

    // CT while waiting for WT.
    apply_stimulus(1, 0, 0, 0, 0);
    apply_stimulus(0, 0, 1, 0, 0);
    check_output("ctearly_SEQERR", 32'(seqerr), 32'd1);
    check_output("ctearly_T", 32'(t), 32'h800);
    apply_stimulus(0, 0, 0, 0, 0);
    triplet(0);
    check_output("recover_T", 32'(t), 32'h001);
    check_output("recover_EOMCY", 32'(eomcy), 32'd1);
    check_output("recover_MCTCNT", 32'(mctcnt), 32'd2);
    apply_stimulus(0, 0, 0, 0, 1);
    check_output("clr_SEQERR", 32'(seqerr), 32'd0);

    // RT and WT rising together.
    apply_stimulus(1, 1, 0, 0, 0);
    check_output("dual_SEQERR", 32'(seqerr), 32'd1);
    check_output("dual_T", 32'(t), 32'h001);
    apply_stimulus(0, 0, 0, 0, 0);
    triplet(0);
    check_output("dual_after_T", 32'(t), 32'h002);
    apply_stimulus(0, 0, 0, 0, 1);

    // Frozen ring, RT held high across STOP release, then stall.
    for (int i = 0; i < 5; i++) triplet(1);
    idle(199, 1);
    apply_stimulus(1, 0, 0, 1, 0);
    check_output("stop_T", 32'(t), 32'h002);
    check_output("stop_MCTCNT", 32'(mctcnt), 32'd2);
    check_output("stop_SEQERR", 32'(seqerr), 32'd0);
    check_output("stop_STALL", 32'(stall), 32'd0);
    apply_stimulus(1, 0, 0, 0, 0);
    idle(62, 0);
    check_output("stall63_STALL", 32'(stall), 32'd0);
    idle(1, 0);
    check_output("stall64_STALL", 32'(stall), 32'd1);
    check_output("stall64_SEQERR", 32'(seqerr), 32'd0);
    triplet(0);
    check_output("poststop_T", 32'(t), 32'h004);
    apply_stimulus(0, 0, 0, 0, 1);
    check_output("clr_STALL", 32'(stall), 32'd0);

    // Counter wrap from 0xFFFF.
    for (int i = 0; i < 9; i++) triplet(0);
    check_output("pre_wrap_T", 32'(t), 32'h800);
    force dut.MCTCNT = 16'hFFFF;
    m_cnt = 65535;
    #1;
    release dut.MCTCNT;
    triplet(0);
    check_output("wrap_MCTCNT", 32'(mctcnt), 32'h0000);
    check_output("wrap_EOMCY", 32'(eomcy), 32'd1);
    check_output("wrap_T", 32'(t), 32'h001);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("wrap_EOMCY_off", 32'(eomcy), 32'd0);

    // Reset at T07 while CT is rising, released with CT still high.
    for (int i = 0; i < 6; i++) triplet(0);
    apply_stimulus(1, 0, 0, 0, 0);
    apply_stimulus(0, 1, 0, 0, 0);
    check_output("t07_T", 32'(t), 32'h040);
    @(negedge clock);
    rt = 0; wt = 0; ct = 1;
    #2;
    sim_rst = 0;
    #1;
    check_reset_values("async");
    apply_stimulus(0, 0, 1, 0, 0);
    apply_stimulus(0, 0, 1, 0, 0);
    sim_rst = 1;
    idle(0, 0);
    apply_stimulus(0, 0, 1, 0, 0);
    apply_stimulus(0, 0, 1, 0, 0);
    check_output("hold_T", 32'(t), 32'h800);
    check_output("hold_SEQERR", 32'(seqerr), 32'd0);
    triplet(0);
    check_output("fresh_T", 32'(t), 32'h001);
    check_output("fresh_EOMCY", 32'(eomcy), 32'd1);
    check_output("fresh_MCTCNT", 32'(mctcnt), 32'd1);
    idle(3, 0);

    @(negedge clock);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timepulse_ring.md
TIMEPULSE_RING -- requirements
Module: timepulse_ring

Interface
REQ-001 CLOCK  input  1  system clock; all state changes on its rising edge.
REQ-002 SIM_RST  input  1  reset, asynchronous, active-low; 0 forces reset state immediately.
REQ-003 RT  input  1  read-timing pulse from the timer, synchronous to CLOCK.
REQ-004 WT  input  1  write-timing pulse from the timer, synchronous to CLOCK.
REQ-005 CT  input  1  clear-timing pulse from the timer, synchronous to CLOCK; ends each time pulse.
REQ-006 STOP  input  1  1 freezes the ring and sequencer.
REQ-007 CLRERR  input  1  1 clears the sticky flags SEQERR and STALL.
REQ-008 T  output  12  one-hot time pulse; bit n-1 = Tn (T01..T12).
REQ-009 TSTAGE  output  4  binary index of active Tn (1..12).
REQ-010 EOMCY  output  1  one-cycle strobe at end of memory cycle (T12->T01).
REQ-011 MCTCNT  output  16  count of completed memory cycles.
REQ-012 SEQERR  output  1  sticky; RT/WT/CT ordering violated.
REQ-013 STALL  output  1  sticky; no CT edge within STALL_LIM cycles while running.
REQ-014 Parameter STALL_LIM, default 64, meaning: CLOCK cycles without a CT edge before STALL sets; legal range 2..1023.

Function
REQ-015 Edge detect: each of RT, WT, CT registered once per CLOCK; a rising edge = sampled 1 with previous sample 0.
REQ-016 Previous-sample registers reset to 1, so inputs already high at reset release produce no edge.
REQ-017 Sequencer states: WAIT_RT, WAIT_WT, WAIT_CT.
REQ-018 WAIT_RT + RT edge only -> WAIT_WT; WAIT_WT + WT edge only -> WAIT_CT; WAIT_CT + CT edge only -> WAIT_RT and ring advances.
REQ-019 Any other edge, or two or more edges in the same cycle, with STOP=0 -> SEQERR set, state -> WAIT_RT, ring not advanced, MCTCNT unchanged.
REQ-020 No edge in a cycle -> state held.
REQ-021 Ring advance occurs on the same CLOCK edge at which the CT edge is detected; T and TSTAGE are registered and change there (zero added latency).
REQ-022 Advance: Tn -> Tn+1 for n<12; T12 -> T01.
REQ-023 On T12 -> T01: EOMCY = 1 for exactly that one cycle; MCTCNT increments by 1, wrapping 0xFFFF -> 0x0000.
REQ-024 T always exactly one-hot; TSTAGE always equals the index of the set bit of T.
REQ-025 STOP=1: all edges ignored (no error, no advance), state forced to WAIT_RT, T/TSTAGE/MCTCNT held, EOMCY=0, stall counter cleared.
REQ-026 Edge-detect registers keep sampling during STOP, so an input high across STOP release produces no edge.
REQ-027 Stall counter: with STOP=0, increments each cycle without a CT edge; cleared on every CT edge (valid or not).
REQ-028 Stall counter reaching STALL_LIM sets STALL; counter saturates at STALL_LIM.
REQ-029 CLRERR=1 clears SEQERR and STALL that cycle; if a set condition occurs in the same cycle, set wins.
REQ-030 SEQERR and STALL are otherwise held until reset.

Reset
REQ-031 SIM_RST=0 asynchronously: T = 0x800 (T12), TSTAGE = 12, state WAIT_RT, EOMCY=0, MCTCNT=0x0000, SEQERR=0, STALL=0, stall counter 0, previous samples 1.
REQ-032 Reset asserted mid-sequence abandons the time pulse in progress; the first valid RT/WT/CT after release yields T01, EOMCY=1, MCTCNT=1.

Verification
REQ-033 Reset, then 12 ordered RT/WT/CT triplets -> T goes 0x001..0x800, TSTAGE 1..12, one EOMCY on the first triplet, MCTCNT=1, SEQERR=0.
REQ-034 From WAIT_WT issue CT edge -> SEQERR=1, T unchanged, next RT/WT/CT advances normally; CLRERR pulse -> SEQERR=0.
REQ-035 RT and WT rising in the same cycle -> SEQERR=1, state WAIT_RT, no advance.
REQ-036 STOP=1 with 5 RT/WT/CT triplets plus 200 idle cycles -> T, MCTCNT unchanged, SEQERR=0, STALL=0; after release, 64 idle cycles -> STALL=1.
REQ-037 Preload MCTCNT to 0xFFFF via 65535 cycles (or force), complete T12->T01 -> MCTCNT=0x0000, EOMCY one cycle.
REQ-038 Assert SIM_RST at T07 in WAIT_CT with CT high -> immediate reset values; release with CT still high -> no advance until a fresh RT/WT/CT.
